// File: rtl/mips_memarb_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM state encoding
// and the width of the outstanding-transfer counter.
package mips_memarb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_P = 2'd1,
    OWN_D = 2'd2
  } state_t;

  // Wide enough for MAX_OUTST up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/mips_memarb_cnt.sv
// Outstanding-transfer counter: counts accepted strobes not yet acknowledged.
// Simultaneous inc/dec holds the value; dec at zero is ignored.
module mips_memarb_cnt
  import mips_memarb_pkg::*;
#(
  parameter int MAX_OUTST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic full,
  output logic empty
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTST);

  logic [CNT_W-1:0] cnt;
  logic             dec_ok;

  assign dec_ok = dec & ~empty;
  assign full   = (cnt == MAX_C);
  assign empty  = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !dec_ok) begin
      cnt <= cnt + 1'b1;
    end else if (dec_ok && !inc) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/mips_memarb.sv
// Arbiter sharing one pipelined Wishbone slave between the MIPS program and
// data masters. Define MIPS_MEMARB_RR_EN for round-robin tie-break (default: dmem wins).
module mips_memarb
  import mips_memarb_pkg::*;
#(
  parameter int MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pmem_cyc_i,
  input  logic        pmem_stb_i,
  input  logic [31:2] pmem_adr_i,
  output logic        pmem_stall_o,
  output logic        pmem_ack_o,
  output logic [31:0] pmem_dat_o,
  input  logic        dmem_cyc_i,
  input  logic        dmem_stb_i,
  input  logic        dmem_we_i,
  input  logic [3:0]  dmem_sel_i,
  input  logic [31:2] dmem_adr_i,
  input  logic [31:0] dmem_dat_i,
  output logic        dmem_stall_o,
  output logic        dmem_ack_o,
  output logic [31:0] dmem_dat_o,
  output logic        mem_cyc_o,
  output logic        mem_stb_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:2] mem_adr_o,
  output logic [31:0] mem_dat_o,
  input  logic        mem_stall_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_dat_i
);

  state_t state_q, state_d;
  logic   full, empty;

`ifdef MIPS_MEMARB_RR_EN
  // Set when dmem should win the next tie; reset leaves pmem preferred.
  logic prio_d;
`endif

  mips_memarb_cnt #(
    .MAX_OUTST(MAX_OUTST)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (mem_stb_o & ~mem_stall_i),
    .dec  (mem_ack_i),
    .clr  (state_d == IDLE),
    .full (full),
    .empty(empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pmem_cyc_i && dmem_cyc_i) begin
`ifdef MIPS_MEMARB_RR_EN
          state_d = prio_d ? OWN_D : OWN_P;
`else
          state_d = OWN_D;
`endif
        end else if (pmem_cyc_i) begin
          state_d = OWN_P;
        end else if (dmem_cyc_i) begin
          state_d = OWN_D;
        end
      end
      // Release on abort, or at a quiet point when the other master waits.
      OWN_P: if (!pmem_cyc_i || (empty && !pmem_stb_i && dmem_cyc_i)) state_d = IDLE;
      OWN_D: if (!dmem_cyc_i || (empty && !dmem_stb_i && pmem_cyc_i)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

`ifdef MIPS_MEMARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_d <= 1'b0;
    end else if (state_q == IDLE && state_d == OWN_P) begin
      prio_d <= 1'b1;
    end else if (state_q == IDLE && state_d == OWN_D) begin
      prio_d <= 1'b0;
    end
  end
`endif

  // Acks are suppressed during rst so a reset mid-transfer never completes one.
  always_comb begin
    mem_cyc_o    = 1'b0;
    mem_stb_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_sel_o    = 4'h0;
    mem_adr_o    = '0;
    mem_dat_o    = 32'h0;
    pmem_stall_o = 1'b1;
    dmem_stall_o = 1'b1;
    pmem_ack_o   = 1'b0;
    dmem_ack_o   = 1'b0;
    case (state_q)
      OWN_P: begin
        mem_cyc_o    = pmem_cyc_i;
        mem_stb_o    = pmem_cyc_i & pmem_stb_i & ~full;
        mem_sel_o    = 4'hF;
        mem_adr_o    = pmem_adr_i;
        pmem_stall_o = mem_stall_i | full;
        pmem_ack_o   = mem_ack_i & pmem_cyc_i & ~rst;
      end
      OWN_D: begin
        mem_cyc_o    = dmem_cyc_i;
        mem_stb_o    = dmem_cyc_i & dmem_stb_i & ~full;
        mem_we_o     = dmem_we_i;
        mem_sel_o    = dmem_sel_i;
        mem_adr_o    = dmem_adr_i;
        mem_dat_o    = dmem_dat_i;
        dmem_stall_o = mem_stall_i | full;
        dmem_ack_o   = mem_ack_i & dmem_cyc_i & ~rst;
      end
      default: ;
    endcase
  end

  assign pmem_dat_o = mem_dat_i;
  assign dmem_dat_o = mem_dat_i;

endmodule
